fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch end of the controller interface.
- Consumes the controller's LoadIR, IncPC, SelPC and LoadPC strobes.
- Owns the PC and the IR, runs the request/acknowledge read to instruction memory, and returns Opcode to the controller.
- Sits between the controller, instruction memory and the accumulator datapath, which supplies register-indirect jump addresses.

Parameters:
- PC_WIDTH, 8, program-counter and memory-address width.
- INSTR_WIDTH, 8, instruction word width; Opcode = IR[INSTR_WIDTH-1 -: 4], Operand = IR[INSTR_WIDTH-5:0].
- TIMEOUT, 15, maximum WAIT cycles before a fetch aborts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- LoadIR  in  1  controller strobe: fetch the instruction at the current PC into IR.
- IncPC  in  1  controller strobe: PC <= PC+1.
- SelPC  in  1  PC source on LoadPC: 0 = Operand (zero-extended), 1 = jump_addr.
- LoadPC  in  1  controller strobe: load PC from the source selected by SelPC.
- jump_addr  in  PC_WIDTH  register-indirect target from the datapath.
- imem_req  out  1  memory read request.
- imem_addr  out  PC_WIDTH  read address; stable while imem_req=1.
- imem_ack  in  1  memory acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  INSTR_WIDTH  instruction word.
- Opcode  out  4  IR opcode field, to the controller.
- Operand  out  INSTR_WIDTH-4  IR operand field.
- PC  out  PC_WIDTH  current program counter.
- ir_valid  out  1  one-cycle pulse: IR updated.
- busy  out  1  fetch in progress.
- fetch_err  out  1  sticky: timeout or overrun occurred.

Behaviour:
- Reset (asynchronous, reset=0): PC=0, IR=0 (Opcode=0, Operand=0), imem_req=0, imem_addr=0, ir_valid=0, busy=0, fetch_err=0, FSM=IDLE, timeout counter=0.
- Reset asserted mid-fetch aborts immediately; the IR is not updated.
- FSM states: IDLE, WAIT.
- IDLE:
  - LoadIR=1 at an edge captures PC into imem_addr, then sets imem_req=1, busy=1 and goes to WAIT.
  - imem_ack in IDLE is ignored.
- WAIT:
  - imem_ack=1 at an edge: IR<=imem_rdata, imem_req<=0, busy<=0, ir_valid<=1 for exactly one cycle, then go to IDLE.
  - Counter increments each WAIT cycle without ack. On reaching TIMEOUT with no ack: abort to IDLE, IR <= 0, fetch_err<=1, ir_valid<=1 (Opcode 0 acts as NOP).
  - LoadIR=1 while in WAIT is dropped and sets fetch_err<=1 (overrun).
- Latency: LoadIR at edge n, imem_req high from n+1. With ack at edge n+1, IR and ir_valid appear after edge n+1, i.e. 2 edges after LoadIR.
- imem_addr is a registered copy, so PC may change freely during WAIT without disturbing the fetch.
- PC update, every edge, independent of the FSM:
  - Priority: LoadPC > IncPC > hold.
  - LoadPC with SelPC=0: PC <= zero-extended current Operand (pre-update IR).
  - LoadPC with SelPC=1: PC <= jump_addr.
  - IncPC: PC <= PC+1, wrapping modulo 2^PC_WIDTH (0xFF -> 0x00).
  - LoadPC and IncPC in the same cycle: LoadPC wins; no increment is applied.
- Opcode, Operand and PC are direct register outputs, with no combinational path from inputs.
- fetch_err is cleared only by reset.

Decomposition:
- Shared package holds:
  - OPCODE_WIDTH=4;
  - the PC source encodings PCSRC_OPERAND=0 and PCSRC_JUMP=1;
  - the fetch state typedef {IDLE, WAIT};
  - NOP_OPCODE=4'b0000.
- One natural sub-module: pc_reg (PC register with load/increment priority mux). The FSM and IR stay in fetch_unit.

Test Plan:
- Reset then LoadIR with PC=0; memory acks in the first request cycle with 0x1A -> imem_addr=0x00, Opcode=0x1, Operand=0xA, ir_valid pulses once 2 edges after LoadIR, busy low afterwards.
- LoadIR with ack delayed 3 cycles, IncPC pulsed during WAIT -> imem_addr stays 0x00 throughout, PC=0x01 after IncPC, IR=rdata at the ack.
- IR=0x27, LoadPC=1 with SelPC=0 -> PC=0x07. Then SelPC=1, jump_addr=0xC3 -> PC=0xC3. Then LoadPC and IncPC asserted together with jump_addr=0x10 -> PC=0x10.
- PC=0xFF with IncPC -> PC=0x00.
- LoadIR with no ack for TIMEOUT=15 cycles -> returns to IDLE, Opcode=0, fetch_err=1, ir_valid pulses; a second LoadIR during WAIT also sets fetch_err.
- Reset driven low mid-WAIT, asynchronously between edges -> imem_req, busy and PC go to 0 immediately; an ack after reset release is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and types for the fetch unit.
// PC source encodings, opcode width, NOP opcode and the fetch FSM states.
package fetch_unit_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic PCSRC_OPERAND = 1'b0;
  localparam logic PCSRC_JUMP    = 1'b1;

  localparam logic [OPCODE_WIDTH-1:0] NOP_OPCODE = 4'b0000;

  typedef enum logic {
    IDLE,
    WAIT
  } fetchState_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// fetch_unit_pc_reg: program counter, load > increment > hold.
// Ports: clk, reset (async low), loadPc, incPc, selPc, operand, jumpAddr -> pc.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                loadPc,
  input  logic                incPc,
  input  logic                selPc,
  input  logic [PC_WIDTH-1:0] operand,
  input  logic [PC_WIDTH-1:0] jumpAddr,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pcNext;

  always_comb begin
    pcNext = pc;
    if (loadPc) begin
      unique case (selPc)
        PCSRC_OPERAND: pcNext = operand;
        PCSRC_JUMP:    pcNext = jumpAddr;
      endcase
    end else if (incPc) begin
      pcNext = pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pcNext;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns PC and IR, runs req/ack reads to instruction memory.
// Ports: controller strobes in, imem req/addr/ack/rdata, Opcode/Operand/PC,
// ir_valid pulse, busy, sticky fetch_err.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           LoadIR,
  input  logic                           IncPC,
  input  logic                           SelPC,
  input  logic                           LoadPC,
  input  logic [PC_WIDTH-1:0]            jump_addr,
  output logic                           imem_req,
  output logic [PC_WIDTH-1:0]            imem_addr,
  input  logic                           imem_ack,
  input  logic [INSTR_WIDTH-1:0]         imem_rdata,
  output logic [OPCODE_WIDTH-1:0]        Opcode,
  output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] Operand,
  output logic [PC_WIDTH-1:0]            PC,
  output logic                           ir_valid,
  output logic                           busy,
  output logic                           fetch_err
);

  localparam int OPND_W = INSTR_WIDTH - OPCODE_WIDTH;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetchState_t            state, stateNext;
  logic [CNT_W-1:0]       cnt, cntNext;
  logic [INSTR_WIDTH-1:0] ir, irNext;
  logic [PC_WIDTH-1:0]    addrNext;
  logic                   validNext;
  logic                   errNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ir        <= '0;
      imem_addr <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      ir        <= irNext;
      imem_addr <= addrNext;
      ir_valid  <= validNext;
      fetch_err <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    irNext    = ir;
    addrNext  = imem_addr;
    validNext = 1'b0;
    errNext   = fetch_err;
    unique case (state)
      IDLE: begin
        if (LoadIR) begin
          stateNext = WAIT;
          addrNext  = PC;
          cntNext   = '0;
        end
      end
      WAIT: begin
        if (LoadIR) errNext = 1'b1;
        if (imem_ack) begin
          irNext    = imem_rdata;
          validNext = 1'b1;
          stateNext = IDLE;
        end else if (cnt == CNT_LAST) begin
          // abort: deliver a NOP so the controller keeps stepping
          irNext    = {NOP_OPCODE, {OPND_W{1'b0}}};
          errNext   = 1'b1;
          validNext = 1'b1;
          stateNext = IDLE;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
    endcase
  end

  assign imem_req = (state == WAIT);
  assign busy     = (state == WAIT);
  assign Opcode   = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign Operand  = ir[OPND_W-1:0];

  fetch_unit_pc_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pcReg (
    .clk     (clk),
    .reset   (reset),
    .loadPc  (LoadPC),
    .incPc   (IncPC),
    .selPc   (SelPC),
    .operand (PC_WIDTH'(ir[OPND_W-1:0])),
    .jumpAddr(jump_addr),
    .pc      (PC)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan plus random stimulus against a
// transaction-level model of PC, IR and the outstanding fetch.
module tb_fetch_unit;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       LoadIR = 1'b0, IncPC = 1'b0, SelPC = 1'b0, LoadPC = 1'b0;
  logic [7:0] jump_addr = '0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = '0;
  logic [3:0] Opcode;
  logic [3:0] Operand;
  logic [7:0] PC;
  logic       ir_valid, busy, fetch_err;

  fetch_unit #(
    .PC_WIDTH(8), .INSTR_WIDTH(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .jump_addr(jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Opcode(Opcode), .Operand(Operand), .PC(PC),
    .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // reference model: one outstanding fetch, counted in whole cycles
  logic [7:0] mPc, mIr, mAddr;
  bit         mPending, mErr, mValid;
  int         mWaits;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 0; mIr = 0; mAddr = 0;
    mPending = 0; mErr = 0; mValid = 0; mWaits = 0;
  endtask

  task automatic modelEdge();
    logic [7:0] oldIr;
    oldIr  = mIr;
    mValid = 0;
    if (!mPending) begin
      if (LoadIR) begin
        mPending = 1; mAddr = mPc; mWaits = 0;
      end
    end else begin
      if (LoadIR) mErr = 1;
      if (imem_ack) begin
        mIr = imem_rdata; mValid = 1; mPending = 0;
      end else begin
        mWaits++;
        if (mWaits == TIMEOUT) begin
          mIr = 0; mErr = 1; mValid = 1; mPending = 0;
        end
      end
    end
    if (LoadPC) mPc = SelPC ? jump_addr : {4'h0, oldIr[3:0]};
    else if (IncPC) mPc = (mPc + 8'd1) % 256;
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".op"},    32'(Opcode),    32'(mIr[7:4]));
    check({tag, ".opnd"},  32'(Operand),   32'(mIr[3:0]));
    check({tag, ".pc"},    32'(PC),        32'(mPc));
    check({tag, ".req"},   32'(imem_req),  32'(mPending));
    check({tag, ".busy"},  32'(busy),      32'(mPending));
    check({tag, ".addr"},  32'(imem_addr), 32'(mAddr));
    check({tag, ".valid"}, 32'(ir_valid),  32'(mValid));
    check({tag, ".err"},   32'(fetch_err), 32'(mErr));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic idle();
    LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0;
    imem_ack = 0;
  endtask

  task automatic doReset();
    idle();
    reset = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("rst");
    reset = 1'b1;
  endtask

  task automatic asyncReset(input string tag);
    #2 reset = 1'b0;
    #1;
    modelReset();
    check({tag, ".req"},  32'(imem_req), 32'd0);
    check({tag, ".busy"}, 32'(busy),     32'd0);
    check({tag, ".pc"},   32'(PC),       32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    doReset();

    // fetch acked in first request cycle
    LoadIR = 1; cycle("t1a");
    check("t1.reqHigh", 32'(imem_req), 32'd1);
    check("t1.noValid", 32'(ir_valid), 32'd0);
    LoadIR = 0; imem_ack = 1; imem_rdata = 8'h1A; cycle("t1b");
    check("t1.op",    32'(Opcode),    32'h1);
    check("t1.opnd",  32'(Operand),   32'hA);
    check("t1.valid", 32'(ir_valid),  32'd1);
    check("t1.addr",  32'(imem_addr), 32'h00);
    imem_ack = 0; cycle("t1c");
    check("t1.pulse", 32'(ir_valid), 32'd0);
    check("t1.busy",  32'(busy),     32'd0);

    // delayed ack, PC moves during WAIT
    LoadIR = 1; cycle("t2a");
    LoadIR = 0; IncPC = 1; cycle("t2b");
    IncPC = 0; cycle("t2c");
    cycle("t2d");
    check("t2.addr", 32'(imem_addr), 32'h00);
    check("t2.pc",   32'(PC),        32'h01);
    imem_ack = 1; imem_rdata = 8'h27; cycle("t2e");
    check("t2.ir", 32'({Opcode, Operand}), 32'h27);
    imem_ack = 0;

    // PC sources and priority
    LoadPC = 1; SelPC = 0; cycle("t3a");
    check("t3.operand", 32'(PC), 32'h07);
    SelPC = 1; jump_addr = 8'hC3; cycle("t3b");
    check("t3.jump", 32'(PC), 32'hC3);
    IncPC = 1; jump_addr = 8'h10; cycle("t3c");
    check("t3.prio", 32'(PC), 32'h10);

    // wrap
    IncPC = 0; jump_addr = 8'hFF; cycle("t4a");
    LoadPC = 0; IncPC = 1; cycle("t4b");
    check("t4.wrap", 32'(PC), 32'h00);
    idle();

    // timeout after a real instruction in IR
    doReset();
    LoadIR = 1; cycle("t5a");
    LoadIR = 0; imem_ack = 1; imem_rdata = 8'h5C; cycle("t5b");
    imem_ack = 0; LoadIR = 1; cycle("t5c");
    LoadIR = 0;
    repeat (TIMEOUT - 1) cycle("t5w");
    check("t5.stillBusy", 32'(busy),      32'd1);
    check("t5.noErrYet",  32'(fetch_err), 32'd0);
    cycle("t5d");
    check("t5.idle",  32'(busy),      32'd0);
    check("t5.nop",   32'(Opcode),    32'h0);
    check("t5.err",   32'(fetch_err), 32'd1);
    check("t5.valid", 32'(ir_valid),  32'd1);

    // overrun on its own
    doReset();
    LoadIR = 1; cycle("t6a");
    cycle("t6b");
    check("t6.overrun", 32'(fetch_err), 32'd1);
    LoadIR = 0; imem_ack = 1; imem_rdata = 8'h33; cycle("t6c");
    idle();

    // async reset mid-WAIT, late ack ignored
    doReset();
    LoadPC = 1; SelPC = 1; jump_addr = 8'h42; cycle("t7a");
    idle(); LoadIR = 1; cycle("t7b");
    LoadIR = 0; cycle("t7c");
    asyncReset("t7rst");
    imem_ack = 1; imem_rdata = 8'h99; cycle("t7d");
    check("t7.noValid", 32'(ir_valid), 32'd0);
    check("t7.irZero",  32'({Opcode, Operand}), 32'h00);
    idle();

    // random
    for (int i = 0; i < 600; i++) begin
      LoadIR     = ($urandom_range(0, 99) < 30);
      IncPC      = ($urandom_range(0, 99) < 25);
      LoadPC     = ($urandom_range(0, 99) < 15);
      SelPC      = $urandom_range(0, 1) != 0;
      jump_addr  = 8'($urandom);
      imem_ack   = ($urandom_range(0, 99) < 35);
      imem_rdata = 8'($urandom);
      if ($urandom_range(0, 63) == 0) asyncReset("rndRst");
      else cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
